// File: rtl/coherence_arbiter.sv
// Two-CPU snooping bus controller: round-robin arbitration, snoop, cache-to-cache or memory fill, write-back.
// Optional memory watchdog compiled in with `define COH_ARB_WDOG_EN.
module coherence_arbiter #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_miss_0,
    input  logic              read_miss_1,
    input  logic              write_miss_0,
    input  logic              write_miss_1,
    input  logic              invalidate_0,
    input  logic              invalidate_1,
    input  logic [ADDR_W-1:0] bico_0,
    input  logic [ADDR_W-1:0] bico_1,
    input  logic [1:0]        block_state_0,
    input  logic [1:0]        block_state_1,
    input  logic              search_found_0,
    input  logic              search_found_1,
    input  logic              mem_rdy,
    output logic              grant_0,
    output logic              grant_1,
    output logic              search_0,
    output logic              search_1,
    output logic [1:0]        datasel_0,
    output logic [1:0]        datasel_1,
    output logic              inv_0,
    output logic              inv_1,
    output logic [ADDR_W+1:0] boci,
    output logic              mem_re,
    output logic              mem_we,
    output logic              done_0,
    output logic              done_1,
    output logic              timeout_err
);

    localparam int unsigned WDOG_W = 8;
    localparam logic [1:0] OP_RM = 2'b01, OP_WM = 2'b10, OP_INV = 2'b11;
    localparam logic [1:0] DS_OTHER = 2'b01, DS_MEM = 2'b10;
    localparam logic [1:0] BS_I = 2'b00, BS_M = 2'b10;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX - 1);
`ifdef COH_ARB_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_EVAL, S_MEM, S_WB, S_DONE} state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_last;
    logic                r_fill;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_timeout;
    logic [1:0]          r_grant;
    logic [1:0]          r_search;
    logic [1:0][1:0]     r_datasel;
    logic [1:0]          r_inv;
    logic [1:0]          r_done;
    logic [ADDR_W+1:0]   r_boci;
    logic                r_mem_re;
    logic                r_mem_we;

    logic                w_req0, w_req1, w_sel, w_y;
    logic [1:0]          w_op0, w_op1, w_op_sel, w_op;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic                w_found_y, w_hit, w_hit_m, w_wdog_hit;
    logic [1:0]          w_bs_y;

    // Request selection: alternate only when both CPUs are requesting.
    assign w_req0     = read_miss_0 | write_miss_0 | invalidate_0;
    assign w_req1     = read_miss_1 | write_miss_1 | invalidate_1;
    assign w_sel      = (w_req0 && w_req1) ? ~r_last : w_req1;
    assign w_op0      = write_miss_0 ? OP_WM : (read_miss_0 ? OP_RM : OP_INV);
    assign w_op1      = write_miss_1 ? OP_WM : (read_miss_1 ? OP_RM : OP_INV);
    assign w_op_sel   = w_sel ? w_op1 : w_op0;
    assign w_addr_sel = w_sel ? bico_1 : bico_0;

    // Snoop result from the non-owning CPU; state I counts as a miss.
    assign w_y        = ~r_owner;
    assign w_op       = r_boci[ADDR_W +: 2];
    assign w_found_y  = w_y ? search_found_1 : search_found_0;
    assign w_bs_y     = w_y ? block_state_1 : block_state_0;
    assign w_hit      = w_found_y && (w_bs_y != BS_I);
    assign w_hit_m    = w_hit && (w_bs_y == BS_M);
    assign w_wdog_hit = WDOG_EN && (r_wdog == WDOG_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_fill    <= 1'b0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_grant   <= '0;
            r_search  <= '0;
            r_datasel <= '0;
            r_inv     <= '0;
            r_done    <= '0;
            r_boci    <= '0;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_search  <= '0;
            r_datasel <= '0;
            r_inv     <= '0;
            r_done    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_owner         <= w_sel;
                        r_grant[w_sel]  <= 1'b1;
                        r_search[~w_sel] <= 1'b1;
                        r_boci          <= {w_op_sel, w_addr_sel};
                        r_state         <= S_SNOOP;
                    end
                end
                S_SNOOP: r_state <= S_EVAL;
                S_EVAL: begin
                    r_wdog <= '0;
                    r_fill <= 1'b0;
                    if (w_op == OP_INV) begin
                        r_inv[w_y]      <= w_hit;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end else if (w_hit) begin
                        r_datasel[r_owner] <= DS_OTHER;
                        r_inv[w_y]         <= (w_op == OP_WM);
                        if (w_hit_m) begin
                            r_mem_we <= 1'b1;
                            r_state  <= S_WB;
                        end else begin
                            r_done[r_owner] <= 1'b1;
                            r_state         <= S_DONE;
                        end
                    end else begin
                        r_mem_re <= 1'b1;
                        r_state  <= S_MEM;
                    end
                end
                // Fill is presented the cycle after mem_rdy, done follows one cycle later.
                S_MEM: begin
                    if (r_fill) begin
                        r_fill          <= 1'b0;
                        r_mem_re        <= 1'b0;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end else if (mem_rdy) begin
                        r_fill             <= 1'b1;
                        r_datasel[r_owner] <= DS_MEM;
                    end else if (w_wdog_hit) begin
                        r_mem_re        <= 1'b0;
                        r_timeout       <= 1'b1;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                S_WB: begin
                    if (mem_rdy || w_wdog_hit) begin
                        r_mem_we        <= 1'b0;
                        r_timeout       <= r_timeout | ~mem_rdy;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_boci  <= '0;
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_0     = r_grant[0];
    assign grant_1     = r_grant[1];
    assign search_0    = r_search[0];
    assign search_1    = r_search[1];
    assign datasel_0   = r_datasel[0];
    assign datasel_1   = r_datasel[1];
    assign inv_0       = r_inv[0];
    assign inv_1       = r_inv[1];
    assign done_0      = r_done[0];
    assign done_1      = r_done[1];
    assign boci        = r_boci;
    assign mem_re      = r_mem_re;
    assign mem_we      = r_mem_we;
    assign timeout_err = r_timeout;

endmodule

// File: doc/coherence_arbiter.md
# coherence_arbiter

Two-requester snooping bus controller for the dual-CPU SMP. It arbitrates read-miss, write-miss and invalidate requests from CPU0 and CPU1, and snoops the non-granted CPU's data cache. It then sources the missing line either cache-to-cache or from d_mem, and sequences write-back and invalidation. It replaces the combinational request steering in the bus with a registered, one-transaction-at-a-time FSM.

## Interface
Parameters:
- ADDR_W, 11, line address width carried on the bus
- WDOG_MAX, 255, memory-wait cycles before abort (used only with watchdog compiled in)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- read_miss_0 / read_miss_1  in  1  read-miss request, held until done_x
- write_miss_0 / write_miss_1  in  1  write-miss request, held until done_x
- invalidate_0 / invalidate_1  in  1  upgrade (S→M) invalidate request, held until done_x
- bico_0 / bico_1  in  ADDR_W  requester line address
- block_state_0 / block_state_1  in  2  snooped line state (00 I, 01 S, 10 M)
- search_found_0 / search_found_1  in  1  snoop hit, valid in EVAL
- mem_rdy  in  1  d_mem access complete
- grant_0 / grant_1  out  1  bus owned by CPUx
- search_0 / search_1  out  1  snoop strobe to CPUx
- datasel_0 / datasel_1  out  2  fill source for CPUx (00 none, 01 other CPU, 10 memory)
- inv_0 / inv_1  out  1  invalidate CPUx copy, one-cycle pulse
- boci  out  ADDR_W+2  {op[1:0], addr}; op 01 RM, 10 WM, 11 INV, 00 idle
- mem_re / mem_we  out  1  d_mem read / write-back strobes, held until mem_rdy
- done_0 / done_1  out  1  transaction complete, one-cycle pulse
- timeout_err  out  1  sticky watchdog abort flag

## Operation
- States: IDLE, SNOOP, EVAL, MEM, WB, DONE.
- IDLE: if any request is present, select a CPU.
  - Round-robin: when both CPUs request, serve the CPU not served last. The pointer resets to favour CPU0.
  - Per-CPU op priority: WM > RM > INV.
  - Latch op, address and owner x; the other CPU is y. Go to SNOOP.
- grant_x is high from SNOOP through DONE inclusive. boci holds {op, addr} over the same span and is 0 otherwise.
- SNOOP: search_y=1 for one cycle. Go to EVAL.
- EVAL: sample search_found_y and block_state_y.
  - INV: pulse inv_y if found. Go to DONE.
  - RM, hit S: datasel_x=01 for one cycle. Go to DONE.
  - RM, hit M: datasel_x=01. Go to WB.
  - WM, hit: datasel_x=01 and inv_y pulse. If M, go to WB; else go to DONE.
  - RM/WM miss: go to MEM.
- MEM: mem_re held. On mem_rdy, datasel_x=10 for one cycle. Go to DONE.
- WB: mem_we held. On mem_rdy, go to DONE.
- DONE: done_x pulse; update the round-robin pointer to x. Go to IDLE. grant_x drops on the next cycle.
- The requester must drop its request in the done_x cycle. A request still high in the following IDLE is a new transaction.
- A hit with block_state 00 is treated as a miss.

## Timing
- All outputs are registered. Reset value of every output is 0; FSM resets to IDLE; pointer resets to favour CPU0.
- Cycle 0 is the request sampled in IDLE.
  - grant at cycle 1; search at cycle 1; EVAL at cycle 2.
  - INV or shared-hit RM: done at cycle 3.
  - Miss: done at cycle 3+N+1, where N is mem_rdy latency (≥1).
- Requests arriving during a transaction wait; no preemption.
- Simultaneous requests from both CPUs are resolved in a single IDLE cycle.
- mem_rdy outside MEM/WB is ignored.
- Reset mid-transaction: all outputs go to 0 immediately (asynchronous) and the FSM returns to IDLE. No done is issued.

## Configuration
- COH_ARB_WDOG_EN defined:
  - An 8-bit counter runs in MEM/WB.
  - On reaching WDOG_MAX without mem_rdy, the FSM goes to DONE with datasel_x=00, mem strobes drop, and timeout_err sets until reset.
- COH_ARB_WDOG_EN undefined: MEM/WB wait indefinitely; timeout_err is tied to 0.

## Test plan
- CPU0 RM 0x040, CPU1 search_found=0, mem_rdy after 3 cycles → grant_0 cycles 1–7, mem_re cycles 3–6, datasel_0=10 at cycle 6, done_0 at cycle 7, boci=0x0840.
- CPU1 WM 0x123, CPU0 hit state M → datasel_1=01 and inv_0 at EVAL, then WB with mem_we until mem_rdy, then done_1.
- CPU0 and CPU1 both RM same cycle after reset → CPU0 served first; CPU1 granted the cycle after CPU0's done returns to IDLE. Repeat → CPU1 first.
- CPU0 INV with CPU1 hit S → inv_1 one cycle, done_0 at cycle 3, no mem strobes.
- Assert rst_n low during MEM → grant, mem_re, boci go to 0 at once; no done; a fresh request after reset is granted normally.
- With COH_ARB_WDOG_EN, hold mem_rdy low → abort after 255 MEM cycles, timeout_err=1, done pulse, datasel=00.
